state_id: RTL

Instruction-decode stage of the 5-stage RV32I pipeline. It sits directly downstream of the fetch stage and contains the IF/ID pipeline register, the 32x32 register file with write-through, and the immediate generator. It also contains the load-use hazard detector, which drives PCWrite back to fetch. It consumes fetch's instruction/pc and feeds the ID/EX register.

---
 rtl/state_id_if.sv | 32 +++
 rtl/state_id.sv | 72 +++++++
 2 files changed

// File: rtl/state_id_if.sv
// state_id_if: fetch/decode/writeback signal bundle for the decode stage
interface state_id_if;
  logic [31:0] if_instruction;
  logic [31:0] if_pc;
  logic        flush;
  logic        ex_MemRead;
  logic [4:0]  ex_rd;
  logic        wb_RegWEn;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        PCWrite;
  logic        id_bubble;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_instruction;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [4:0]  id_rd;
  logic [31:0] id_rs1_data;
  logic [31:0] id_rs2_data;
  logic [31:0] id_imm;
  modport slave (
    input  if_instruction, if_pc, flush, ex_MemRead, ex_rd, wb_RegWEn, wb_rd, wb_data,
    output PCWrite, id_bubble, id_valid, id_pc, id_instruction, id_rs1, id_rs2, id_rd,
           id_rs1_data, id_rs2_data, id_imm
  );
  modport master (
    output if_instruction, if_pc, flush, ex_MemRead, ex_rd, wb_RegWEn, wb_rd, wb_data,
    input  PCWrite, id_bubble, id_valid, id_pc, id_instruction, id_rs1, id_rs2, id_rd,
           id_rs1_data, id_rs2_data, id_imm
  );
endinterface

// File: rtl/state_id.sv
// state_id: RV32I decode stage with IF/ID register, register file, immediate generator and load-use stall
module state_id #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter bit RF_CLEAR_ON_RESET = 1'b1
) (
  input logic clk,
  input logic rst,
  state_id_if.slave bus
);
  logic [31:0] r_instr;
  logic [31:0] r_pc;
  logic        r_valid;
  logic [31:0] r_rf [0:31];
  logic [6:0]  w_op;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic        w_uses_rs1;
  logic        w_uses_rs2;
  logic        w_stall;
  logic        w_wen;
  logic [31:0] w_imm;
  assign w_op  = r_instr[6:0];
  assign w_rs1 = r_instr[19:15];
  assign w_rs2 = r_instr[24:20];
  assign w_wen = bus.wb_RegWEn && bus.wb_rd != 5'd0;
  assign w_uses_rs1 = !(w_op == 7'b0110111 || w_op == 7'b0010111 || w_op == 7'b1101111);
  assign w_uses_rs2 = w_op == 7'b0110011 || w_op == 7'b0100011 || w_op == 7'b1100011;
  assign w_stall = r_valid && bus.ex_MemRead && bus.ex_rd != 5'd0 &&
                   ((w_uses_rs1 && bus.ex_rd == w_rs1) || (w_uses_rs2 && bus.ex_rd == w_rs2));
  always_comb begin
    w_imm = (w_op == 7'b0010011 || w_op == 7'b0000011 || w_op == 7'b1100111) ? {{20{r_instr[31]}}, r_instr[31:20]} :
            (w_op == 7'b0100011) ? {{20{r_instr[31]}}, r_instr[31:25], r_instr[11:7]} :
            (w_op == 7'b1100011) ? {{19{r_instr[31]}}, r_instr[31], r_instr[7], r_instr[30:25], r_instr[11:8], 1'b0} :
            (w_op == 7'b0110111 || w_op == 7'b0010111) ? {r_instr[31:12], 12'b0} :
            (w_op == 7'b1101111) ? {{11{r_instr[31]}}, r_instr[31], r_instr[19:12], r_instr[20], r_instr[30:21], 1'b0} :
            32'd0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_instr <= NOP_INSTR;
      r_pc    <= 32'd0;
      r_valid <= 1'b0;
    end else if (bus.flush) begin
      r_instr <= NOP_INSTR;
      r_pc    <= bus.if_pc;
      r_valid <= 1'b0;
    end else if (!w_stall) begin
      r_instr <= bus.if_instruction;
      r_pc    <= bus.if_pc;
      r_valid <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      if (RF_CLEAR_ON_RESET)
        for (int i = 0; i < 32; i++) r_rf[i] <= 32'd0;
    end else if (w_wen) begin
      r_rf[bus.wb_rd] <= bus.wb_data;
    end
  end
  assign bus.PCWrite        = !w_stall || bus.flush;
  assign bus.id_bubble      = w_stall || !r_valid;
  assign bus.id_valid       = r_valid;
  assign bus.id_pc          = r_pc;
  assign bus.id_instruction = r_instr;
  assign bus.id_rs1         = w_rs1;
  assign bus.id_rs2         = w_rs2;
  assign bus.id_rd          = r_instr[11:7];
  assign bus.id_imm         = w_imm;
  assign bus.id_rs1_data    = w_rs1 == 5'd0 ? 32'd0 : (w_wen && bus.wb_rd == w_rs1) ? bus.wb_data : r_rf[w_rs1];
  assign bus.id_rs2_data    = w_rs2 == 5'd0 ? 32'd0 : (w_wen && bus.wb_rd == w_rs2) ? bus.wb_data : r_rf[w_rs2];
endmodule
